// File: rtl/rng_fetch_pkg.sv
// Shared types and register map for the RNG fetch engine.
// Register offsets are 8-byte indices into the RNG window.
package rng_fetch_pkg;

   typedef enum logic [2:0] {
      IDLE,
      POLL,
      RD_LO,
      RD_HI,
      PUSH,
      BACKOFF
   } fetch_state_e;

   localparam logic [3:0] REG_RAND_LO = 4'd12;
   localparam logic [3:0] REG_RAND_HI = 4'd13;
   localparam logic [3:0] REG_VALID   = 4'd14;

   function automatic logic [63:0] reg_addr(
      input logic [63:0] base,
      input logic [3:0]  idx
   );
      return base + {57'b0, idx, 3'b000};
   endfunction

endpackage

// File: rtl/rng_fetch_fifo.sv
// Synchronous FIFO holding reassembled random words.
// DEPTH must be a power of two; pointers wrap naturally.
module rng_fetch_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned DW    = 64,
   localparam int unsigned AW   = $clog2(DEPTH),
   localparam int unsigned LW   = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          push_i,
   input  logic [DW-1:0] data_i,
   input  logic          pop_i,
   output logic [DW-1:0] data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wptr_q;
   logic [AW-1:0] rptr_q;
   logic [LW-1:0] level_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (level_q == LW'(DEPTH));
   assign empty_o = (level_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rptr_q];
   assign level_o = level_q;

   // Storage array; contents are don't-care while the slot is empty.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= data_i;
   end

   // Read/write pointers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + AW'(1);
         if (do_pop)  rptr_q <= rptr_q + AW'(1);
      end
   end

   // Occupancy; simultaneous push and pop leaves it unchanged.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         level_q <= '0;
      end else begin
         unique case ({do_push, do_pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

endmodule

// File: rtl/rng_fetch_master.sv
// Polls the RNG register window, assembles 64-bit words and buffers them.
// Optional duplicate-word rejection: define RNG_FETCH_DUPCHK_EN.
module rng_fetch_master
   import rng_fetch_pkg::*;
#(
   parameter int unsigned AXI_ADDR_WIDTH = 64,
   parameter logic [63:0] BASE_ADDR      = 64'h0,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter int unsigned POLL_GAP       = 8,
   parameter int unsigned TIMEOUT_POLLS  = 1024,
   localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic                      enable_i,
   input  logic                      err_clr_i,
   output logic                      bus_en_o,
   output logic                      bus_we_o,
   output logic [AXI_ADDR_WIDTH-1:0] bus_addr_o,
   output logic [63:0]               bus_wdata_o,
   input  logic [63:0]               bus_rdata_i,
   output logic [63:0]               rand_o,
   output logic                      rand_valid_o,
   input  logic                      rand_ready_i,
   output logic [LW-1:0]             fifo_level_o,
   output logic                      err_timeout_o,
   output logic                      err_dup_o
);

   localparam int unsigned PW = $clog2(TIMEOUT_POLLS + 1);
   localparam int unsigned GW = $clog2(POLL_GAP + 1);
   localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);

   fetch_state_e state_q, state_d;
   logic [PW-1:0] poll_cnt_q;
   logic [GW-1:0] gap_cnt_q;
   logic [31:0]   lo_q;
   logic [63:0]   word_q;
   logic          err_timeout_q;
   logic          dup;
   logic          fifo_push;
   logic          fifo_full;
   logic          fifo_empty;
   logic          popping;
   logic [LW-1:0] level_nx;
   logic          rd_valid;
   logic          poll_hit;
   logic          gap_done;
   logic [3:0]    idx;
   logic          unused_rdata;

   assign unused_rdata = ^bus_rdata_i[63:32];
   assign rd_valid  = bus_rdata_i[0];
   assign poll_hit  = (poll_cnt_q == PW'(TIMEOUT_POLLS - 1));
   assign gap_done  = (gap_cnt_q == GW'(POLL_GAP - 1));
   assign fifo_push = (state_q == PUSH) && !dup;
   assign popping   = rand_ready_i && !fifo_empty;
   assign level_nx  = fifo_level_o + LW'(fifo_push) - LW'(popping);

   assign bus_we_o      = 1'b0;
   assign bus_wdata_o   = '0;
   assign rand_valid_o  = !fifo_empty;
   assign err_timeout_o = err_timeout_q;

   // State register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   // Next-state: one access per state, back off between empty polls.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (enable_i && !err_timeout_q && !fifo_full)
               state_d = POLL;
         end
         POLL: begin
            if (rd_valid)      state_d = RD_LO;
            else if (poll_hit) state_d = IDLE;
            else               state_d = BACKOFF;
         end
         RD_LO: state_d = RD_HI;
         RD_HI: state_d = PUSH;
         PUSH: begin
            if (enable_i && (level_nx != DEPTH_L))
               state_d = POLL;
            else
               state_d = IDLE;
         end
         BACKOFF: begin
            if (!enable_i)    state_d = IDLE;
            else if (gap_done) state_d = POLL;
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus strobe and register index decode.
   always_comb begin
      bus_en_o = 1'b0;
      idx      = REG_VALID;
      unique case (state_q)
         POLL:  begin bus_en_o = 1'b1; idx = REG_VALID;   end
         RD_LO: begin bus_en_o = 1'b1; idx = REG_RAND_LO; end
         RD_HI: begin bus_en_o = 1'b1; idx = REG_RAND_HI; end
         default: ;
      endcase
      bus_addr_o = bus_en_o ?
         AXI_ADDR_WIDTH'(reg_addr(BASE_ADDR, idx)) : '0;
   end

   // Consecutive empty-poll counter and backoff timer.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         poll_cnt_q <= '0;
         gap_cnt_q  <= '0;
      end else begin
         if (state_q == POLL)
            poll_cnt_q <= rd_valid ? '0 : poll_cnt_q + PW'(1);
         else if (err_clr_i)
            poll_cnt_q <= '0;
         gap_cnt_q <= (state_q == BACKOFF) ? gap_cnt_q + GW'(1) : '0;
      end
   end

   // Word assembly from the two halves.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lo_q   <= '0;
         word_q <= '0;
      end else begin
         if (state_q == RD_LO) lo_q <= bus_rdata_i[31:0];
         if (state_q == RD_HI) word_q <= {bus_rdata_i[31:0], lo_q};
      end
   end

   // Sticky timeout flag; a set beats a simultaneous clear.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         err_timeout_q <= 1'b0;
      else if ((state_q == POLL) && !rd_valid && poll_hit)
         err_timeout_q <= 1'b1;
      else if (err_clr_i)
         err_timeout_q <= 1'b0;
   end

`ifdef RNG_FETCH_DUPCHK_EN
   logic [63:0] prev_q;
   logic        err_dup_q;

   assign dup       = (state_q == PUSH) && (word_q == prev_q);
   assign err_dup_o = err_dup_q;

   // Last word actually pushed, and sticky duplicate flag.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q    <= '0;
         err_dup_q <= 1'b0;
      end else begin
         if (fifo_push) prev_q <= word_q;
         if (dup)            err_dup_q <= 1'b1;
         else if (err_clr_i) err_dup_q <= 1'b0;
      end
   end
`else
   assign dup       = 1'b0;
   assign err_dup_o = 1'b0;
`endif

   rng_fetch_fifo #(
      .DEPTH (FIFO_DEPTH),
      .DW    (64)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (fifo_push),
      .data_i  (word_q),
      .pop_i   (rand_ready_i),
      .data_o  (rand_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level_o)
   );

endmodule

// File: tb/tb_rng_fetch_master.sv
// Directed bench for rng_fetch_master with a combinational RNG responder.
// Duplicate-check expectations follow RNG_FETCH_DUPCHK_EN.
module tb_rng_fetch_master;

   logic        clk;
   logic        rst_ni;
   logic        enable_i;
   logic        err_clr_i;
   logic        bus_en_o;
   logic        bus_we_o;
   logic [63:0] bus_addr_o;
   logic [63:0] bus_wdata_o;
   logic [63:0] bus_rdata_i;
   logic [63:0] rand_o;
   logic        rand_valid_o;
   logic        rand_ready_i;
   logic [2:0]  fifo_level_o;
   logic        err_timeout_o;
   logic        err_dup_o;

   rng_fetch_master #(
      .AXI_ADDR_WIDTH (64),
      .BASE_ADDR      (64'h0),
      .FIFO_DEPTH     (4),
      .POLL_GAP       (8),
      .TIMEOUT_POLLS  (4)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_ni),
      .enable_i      (enable_i),
      .err_clr_i     (err_clr_i),
      .bus_en_o      (bus_en_o),
      .bus_we_o      (bus_we_o),
      .bus_addr_o    (bus_addr_o),
      .bus_wdata_o   (bus_wdata_o),
      .bus_rdata_i   (bus_rdata_i),
      .rand_o        (rand_o),
      .rand_valid_o  (rand_valid_o),
      .rand_ready_i  (rand_ready_i),
      .fifo_level_o  (fifo_level_o),
      .err_timeout_o (err_timeout_o),
      .err_dup_o     (err_dup_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic        rsp_valid;
   logic [31:0] rsp_lo;
   logic [31:0] rsp_hi;
   logic        auto_mode;
   logic [31:0] seq;
   int          cyc = 0;
   int          we_bad = 0;
   logic [63:0] acc_addr[$];
   int          acc_cyc[$];

   // Register responder: upper halves carry junk that must be ignored.
   always_comb begin
      bus_rdata_i = '0;
      case (bus_addr_o)
         64'd112: bus_rdata_i = {63'b0, rsp_valid};
         64'd96:  bus_rdata_i = {32'hAAAA_AAAA, auto_mode ? seq : rsp_lo};
         64'd104: bus_rdata_i = {32'h5555_5555, rsp_hi};
         default: bus_rdata_i = '0;
      endcase
   end

   // Access log sampled on the capturing edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (bus_en_o) begin
         acc_addr.push_back(bus_addr_o);
         acc_cyc.push_back(cyc);
         if (bus_we_o || bus_wdata_o != 64'd0) we_bad <= we_bad + 1;
         if (auto_mode && bus_addr_o == 64'd96) seq <= seq + 32'd1;
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clear_log();
      acc_addr.delete();
      acc_cyc.delete();
   endtask

   task automatic pop1();
      rand_ready_i = 1'b1;
      tick();
      rand_ready_i = 1'b0;
   endtask

   // Raise enable for 'hold' cycles, return cycles until the level moves.
   task automatic fetch_one(input int hold, output int lat);
      logic [2:0] lvl0;
      lvl0 = fifo_level_o;
      enable_i = 1'b1;
      lat = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         lat++;
         if (lat == hold) enable_i = 1'b0;
         if (fifo_level_o != lvl0) break;
      end
      enable_i = 1'b0;
   endtask

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      int          hold;
      logic [63:0] exp;
   } vec_t;

   vec_t vt[4];
   int   lat;
   int   n;
   logic [47:0] pk;

   initial begin
      vt[0] = '{32'h1111_2222, 32'h3333_4444, 1, 64'h3333_4444_1111_2222};
      vt[1] = '{32'h0000_0000, 32'hFFFF_FFFF, 2, 64'hFFFF_FFFF_0000_0000};
      vt[2] = '{32'h8765_4321, 32'h0000_0001, 3, 64'h0000_0001_8765_4321};
      vt[3] = '{32'hCAFE_F00D, 32'h1234_5678, 1, 64'h1234_5678_CAFE_F00D};

      rst_ni = 1'b0;
      enable_i = 1'b0;
      err_clr_i = 1'b0;
      rand_ready_i = 1'b0;
      rsp_valid = 1'b1;
      rsp_lo = '0;
      rsp_hi = '0;
      auto_mode = 1'b0;
      seq = '0;
      repeat (3) tick();
      chk("rst_bus_en", {63'b0, bus_en_o}, 64'd0);
      chk("rst_addr", bus_addr_o, 64'd0);
      chk("rst_rand", rand_o, 64'd0);
      chk("rst_valid", {63'b0, rand_valid_o}, 64'd0);
      chk("rst_level", {61'b0, fifo_level_o}, 64'd0);
      chk("rst_errs", {62'b0, err_timeout_o, err_dup_o}, 64'd0);
      rst_ni = 1'b1;
      tick();

      // Single fetches, enable dropped at various points.
      for (int i = 0; i < 4; i++) begin
         rsp_lo = vt[i].lo;
         rsp_hi = vt[i].hi;
         clear_log();
         fetch_one(vt[i].hold, lat);
         chk("vec_lat", 64'(lat), 64'd5);
         chk("vec_word", rand_o, vt[i].exp);
         chk("vec_level", {61'b0, fifo_level_o}, 64'd1);
         repeat (4) tick();
         chk("vec_nacc", 64'(acc_addr.size()), 64'd3);
         pk = '0;
         for (int k = 0; k < acc_addr.size() && k < 3; k++)
            pk = {pk[31:0], acc_addr[k][15:0]};
         chk("vec_addr", {16'b0, pk}, 64'h0000_0070_0060_0068);
         pop1();
         chk("vec_pop", {61'b0, fifo_level_o}, 64'd0);
      end

      // Fill with consumer stalled; engine must stop at four words.
      auto_mode = 1'b1;
      seq = 32'h100;
      rsp_hi = 32'hC0DE_0000;
      clear_log();
      enable_i = 1'b1;
      for (int c = 0; c < 100 && fifo_level_o != 3'd4; c++) tick();
      chk("fill_level", {61'b0, fifo_level_o}, 64'd4);
      repeat (10) tick();
      n = acc_addr.size();
      chk("fill_nacc", 64'(n), 64'd12);
      repeat (30) tick();
      chk("fill_quiet", 64'(acc_addr.size()), 64'(n));
      enable_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("fill_order", rand_o, {32'hC0DE_0000, 32'h100 + 32'(i)});
         pop1();
      end
      chk("fill_empty", {63'b0, rand_valid_o}, 64'd0);
      auto_mode = 1'b0;

      // Push and pop in the same cycle at level 2.
      rsp_hi = 32'h2222_0000;
      rsp_lo = 32'h0000_00A0;
      fetch_one(1, lat);
      rsp_lo = 32'h0000_00A1;
      fetch_one(1, lat);
      chk("pp_level2", {61'b0, fifo_level_o}, 64'd2);
      rsp_lo = 32'h0000_00A2;
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      repeat (3) tick();
      rand_ready_i = 1'b1;
      tick();
      rand_ready_i = 1'b0;
      chk("pp_level", {61'b0, fifo_level_o}, 64'd2);
      chk("pp_head1", rand_o, 64'h2222_0000_0000_00A1);
      pop1();
      chk("pp_head2", rand_o, 64'h2222_0000_0000_00A2);
      pop1();

      // Timeout after four not-valid polls.
      rsp_valid = 1'b0;
      clear_log();
      enable_i = 1'b1;
      for (int c = 0; c < 100 && !err_timeout_o; c++) tick();
      chk("to_flag", {63'b0, err_timeout_o}, 64'd1);
      chk("to_npoll", 64'(acc_addr.size()), 64'd4);
      for (int k = 0; k + 1 < acc_cyc.size(); k++) begin
         chk("to_gap", 64'(acc_cyc[k+1] - acc_cyc[k]), 64'd9);
         chk("to_addr", acc_addr[k], 64'd112);
      end
      repeat (30) tick();
      chk("to_quiet", 64'(acc_addr.size()), 64'd4);
      rsp_valid = 1'b1;
      rsp_lo = 32'h0BAD_0001;
      rsp_hi = 32'h0BAD_0002;
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("to_clr", {63'b0, err_timeout_o}, 64'd0);
      tick();
      enable_i = 1'b0;
      for (int c = 0; c < 20 && fifo_level_o == 3'd0; c++) tick();
      chk("to_resume", rand_o, 64'h0BAD_0002_0BAD_0001);
      repeat (3) tick();
      pop1();

      // Identical word fetched twice.
      rsp_lo = 32'h0000_0001;
      rsp_hi = 32'hDEAD_BEEF;
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      repeat (7) tick();
      enable_i = 1'b1;
      tick();
      enable_i = 1'b0;
      repeat (7) tick();
`ifdef RNG_FETCH_DUPCHK_EN
      chk("dup_level", {61'b0, fifo_level_o}, 64'd1);
      chk("dup_flag", {63'b0, err_dup_o}, 64'd1);
`else
      chk("dup_level", {61'b0, fifo_level_o}, 64'd2);
      chk("dup_flag", {63'b0, err_dup_o}, 64'd0);
`endif
      chk("dup_head", rand_o, 64'hDEAD_BEEF_0000_0001);
      err_clr_i = 1'b1;
      tick();
      err_clr_i = 1'b0;
      chk("dup_clr", {63'b0, err_dup_o}, 64'd0);

      // Asynchronous reset mid-fetch empties the FIFO.
      rsp_lo = 32'h5A5A_0000;
      enable_i = 1'b1;
      repeat (2) tick();
      rst_ni = 1'b0;
      #1;
      chk("arst_level", {61'b0, fifo_level_o}, 64'd0);
      chk("arst_bus", {63'b0, bus_en_o}, 64'd0);
      enable_i = 1'b0;
      tick();
      rst_ni = 1'b1;
      tick();

      chk("bus_we", 64'(we_bad), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
